way_encoder_pipe: RTL and testbench

- Parametrised N-way one-hot/priority encoder with a one-deep registered output stage and valid/ready handshake.
- Converts the per-way hit vector of the set-associative write-back cache into a way index for data-array muxing and replacement update.
- Adds hit/multi-hit flags, selectable strict-one-hot or priority mode, and back-pressure; replaces fixed-width combinational encoding in the cache datapath.

---
 rtl/way_encoder_pipe.sv | 92 +++++++++
 tb/tb_way_encoder_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/way_encoder_pipe.sv
// way_encoder_pipe: N-way one-hot/priority encoder with a one-deep registered valid/ready stage.
// Optional macro WAY_ENCODER_MULTI_CNT_EN enables the saturating multi-hit counter (else multi_cnt = 0).
`default_nettype none

module way_encoder_pipe #(
  parameter  int N_WAYS    = 4,
  parameter  int PRIO_MODE = 0,
  parameter  int CNT_W     = 8,
  localparam int IDX_W     = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_WAYS-1:0] in_vec,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_hit,
  output logic              out_multi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  multi_cnt
);

  logic             valid_q, hit_q, multi_q;
  logic [IDX_W-1:0] idx_q;
  logic             w_accept;
  logic             hit_d, multi_d;
  logic [IDX_W-1:0] idx_d, or_idx, low_idx;

  assign in_ready = !valid_q | out_ready;
  assign w_accept = in_valid & in_ready;

  // OR of set positions is the index only when exactly one bit is set.
  always_comb begin
    hit_d   = 1'b0;
    multi_d = 1'b0;
    or_idx  = '0;
    low_idx = '0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (in_vec[i]) begin
        low_idx = IDX_W'(i);
        or_idx  = or_idx | IDX_W'(i);
        if (hit_d) multi_d = 1'b1;
        hit_d = 1'b1;
      end
    end
    if (PRIO_MODE != 0) idx_d = low_idx;
    else                idx_d = (hit_d && !multi_d) ? or_idx : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      multi_q <= 1'b0;
    end else if (w_accept) begin
      valid_q <= 1'b1;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      multi_q <= multi_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_hit   = hit_q;
  assign out_multi = multi_q;

`ifdef WAY_ENCODER_MULTI_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (w_accept && multi_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign multi_cnt = cnt_q;
`else
  assign multi_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_way_encoder_pipe.sv
// Self-checking bench for way_encoder_pipe: directed literal checks plus randomized traffic vs a behavioural model.
`default_nettype none

module tb_way_encoder_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       iv = 1'b0, ordy = 1'b0;
  logic [3:0] a_vec = '0;
  logic [7:0] b_vec = '0;
  logic       a_ir, a_ov, a_hit, a_multi, b_ir, b_ov, b_hit, b_multi;
  logic [1:0] a_idx, a_cnt;
  logic [2:0] b_idx;
  logic [7:0] b_cnt;

  way_encoder_pipe #(.N_WAYS(4), .PRIO_MODE(0), .CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .in_vec(a_vec), .in_valid(iv), .in_ready(a_ir),
    .out_idx(a_idx), .out_hit(a_hit), .out_multi(a_multi), .out_valid(a_ov),
    .out_ready(ordy), .multi_cnt(a_cnt));

  way_encoder_pipe #(.N_WAYS(8), .PRIO_MODE(1), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .in_vec(b_vec), .in_valid(iv), .in_ready(b_ir),
    .out_idx(b_idx), .out_hit(b_hit), .out_multi(b_multi), .out_valid(b_ov),
    .out_ready(ordy), .multi_cnt(b_cnt));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int expc(input int v);
`ifdef WAY_ENCODER_MULTI_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Behavioural model: transaction-level view of what the stage holds.
  typedef struct {
    int v, idx, hit, multi, cnt;
  } mst_t;

  function automatic int popc(input logic [7:0] v, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int enc(input logic [7:0] v, input int n, input int prio);
    int pc = popc(v, n);
    if (prio == 0 && pc != 1) return 0;
    for (int i = 0; i < n; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic mst_t step(input mst_t s, input logic rstn, input logic [7:0] vec,
                                input int n, input int prio, input int cw,
                                input logic vin, input logic rdy);
    mst_t t = s;
    if (!rstn) begin
      t = '{0, 0, 0, 0, 0};
    end else if (vin && (s.v == 0 || rdy)) begin
      t.v     = 1;
      t.idx   = enc(vec, n, prio);
      t.hit   = (popc(vec, n) >= 1) ? 1 : 0;
      t.multi = (popc(vec, n) >= 2) ? 1 : 0;
      if (t.multi == 1 && s.cnt < (1 << cw) - 1) t.cnt = s.cnt + expc(1);
    end else if (rdy) begin
      t.v = 0;
    end
    return t;
  endfunction

  mst_t ma = '{0, 0, 0, 0, 0};
  mst_t mb = '{0, 0, 0, 0, 0};
  bit   cmp_en = 1'b0;

  always @(posedge clk) begin
    ma = step(ma, rst, {4'b0, a_vec}, 4, 0, 2, iv, ordy);
    mb = step(mb, rst, b_vec, 8, 1, 8, iv, ordy);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_a_valid", a_ov, ma.v);
      chk("m_a_ready", a_ir, (ma.v == 0 || ordy) ? 1 : 0);
      chk("m_a_cnt", a_cnt, ma.cnt);
      chk("m_b_valid", b_ov, mb.v);
      chk("m_b_ready", b_ir, (mb.v == 0 || ordy) ? 1 : 0);
      chk("m_b_cnt", b_cnt, mb.cnt);
      if (ma.v != 0) begin
        chk("m_a_idx", a_idx, ma.idx);
        chk("m_a_hit", a_hit, ma.hit);
        chk("m_a_multi", a_multi, ma.multi);
      end
      if (mb.v != 0) begin
        chk("m_b_idx", b_idx, mb.idx);
        chk("m_b_hit", b_hit, mb.hit);
        chk("m_b_multi", b_multi, mb.multi);
      end
    end
  end

  // Inputs change just after the falling edge, clear of both the sampling and active edges.
  task automatic cyc(input logic [3:0] va, input logic [7:0] vb, input logic v,
                     input logic r, input logic rn);
    #1;
    a_vec = va; b_vec = vb; iv = v; ordy = r; rst = rn;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    cyc(4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    cmp_en = 1'b1;
    cyc(4'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("rst_a_valid", a_ov, 0);
    chk("rst_a_idx", a_idx, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_b_valid", b_ov, 0);

    for (int k = 0; k < 4; k++) begin
      cyc(4'(1 << k), 8'h00, 1'b1, 1'b1, 1'b1);
      chk("stream_idx", a_idx, k);
      chk("stream_valid", a_ov, 1);
      chk("stream_hit", a_hit, 1);
      chk("stream_multi", a_multi, 0);
    end

    cyc(4'b0110, 8'b1010_0100, 1'b1, 1'b1, 1'b1);
    chk("strict_multi_idx", a_idx, 0);
    chk("strict_multi_hit", a_hit, 1);
    chk("strict_multi_flag", a_multi, 1);
    chk("strict_multi_cnt", a_cnt, expc(1));
    chk("prio_idx_low", b_idx, 2);
    chk("prio_multi", b_multi, 1);

    cyc(4'b0000, 8'b1000_0000, 1'b1, 1'b1, 1'b1);
    chk("zero_idx", a_idx, 0);
    chk("zero_hit", a_hit, 0);
    chk("zero_multi", a_multi, 0);
    chk("prio_idx_top", b_idx, 7);
    chk("prio_single", b_multi, 0);

    cyc(4'b0010, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("bp_first", a_idx, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b1000, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("bp_in_ready", a_ir, 0);
      chk("bp_hold_idx", a_idx, 1);
      chk("bp_hold_valid", a_ov, 1);
    end
    cyc(4'b1000, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("bp_release_idx", a_idx, 3);
    cyc(4'b0000, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("bp_drained", a_ov, 0);

    cyc(4'b1000, 8'h00, 1'b1, 1'b1, 1'b1);
    cyc(4'b0011, 8'hff, 1'b1, 1'b1, 1'b0);
    chk("midrst_a_valid", a_ov, 0);
    chk("midrst_a_idx", a_idx, 0);
    chk("midrst_a_hit", a_hit, 0);
    chk("midrst_a_multi", a_multi, 0);
    chk("midrst_b_valid", b_ov, 0);
    chk("midrst_b_cnt", b_cnt, 0);

    for (int k = 0; k < 5; k++) begin
      cyc(4'b1100, 8'b0000_0011, 1'b1, 1'b1, 1'b1);
      chk("sat_a_cnt", a_cnt, expc((k + 1 > 3) ? 3 : k + 1));
      chk("sat_b_cnt", b_cnt, expc(k + 1));
    end
    cyc(4'h0, 8'h00, 1'b0, 1'b1, 1'b1);

    repeat (3000) begin
      logic [7:0] r8;
      int         sel;
      sel = $urandom_range(0, 3);
      r8  = 8'($urandom);
      if (sel == 1) r8 = 8'(1 << $urandom_range(0, 7));
      if (sel == 2) r8 = 8'h00;
      cyc(r8[3:0] | ((sel == 1) ? 4'(1 << $urandom_range(0, 3)) & {4{r8 == 0}} : 4'h0),
          r8, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 59) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
